// File: rtl/tdp_ram_requester.sv
// ---------------------------------------------------------------------------
// tdp_ram_requester
//
// Initiator side of a true-dual-port block RAM. After reset it clears the
// first DEPTH words: two words per cycle, even addresses on RAM port A and odd
// addresses on RAM port B. It then turns two valid/ready request streams (A, B)
// into RAM port A/B cycles. Both ports may not touch the same address in one
// cycle when either of them writes, so the RAM never returns X data.
//
// Ports
//   clk                          single clock, all logic on posedge
//   rst                          asynchronous, active-high reset
//   init_done                    high once the RAM clear has completed
//   req_valid_x / req_ready_x    request handshake, port x in {a, b}
//   req_we_x                     1 = write, 0 = read
//   req_addr_x, req_wdata_x      request address / write data
//   rsp_valid_x, rsp_data_x      read response, one cycle after acceptance,
//                                no backpressure
//   ram_a_x, ram_wd_x, ram_we_x  RAM port x address / write data / write enable
//   ram_rd_x                     RAM port x registered read data
// ---------------------------------------------------------------------------
module tdp_ram_requester #(
    parameter int               ABITS      = 10,
    parameter int               DBITS      = 36,
    parameter int               DEPTH      = 1024,
    parameter logic [DBITS-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_done,

    input  logic             req_valid_a,
    output logic             req_ready_a,
    input  logic             req_we_a,
    input  logic [ABITS-1:0] req_addr_a,
    input  logic [DBITS-1:0] req_wdata_a,
    output logic             rsp_valid_a,
    output logic [DBITS-1:0] rsp_data_a,

    input  logic             req_valid_b,
    output logic             req_ready_b,
    input  logic             req_we_b,
    input  logic [ABITS-1:0] req_addr_b,
    input  logic [DBITS-1:0] req_wdata_b,
    output logic             rsp_valid_b,
    output logic [DBITS-1:0] rsp_data_b,

    output logic [ABITS-1:0] ram_a_a,
    output logic [DBITS-1:0] ram_wd_a,
    output logic             ram_we_a,
    input  logic [DBITS-1:0] ram_rd_a,

    output logic [ABITS-1:0] ram_a_b,
    output logic [DBITS-1:0] ram_wd_b,
    output logic             ram_we_b,
    input  logic [DBITS-1:0] ram_rd_b
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Last init cycle: word pair (DEPTH-2, DEPTH-1).
    localparam logic [ABITS-1:0] CNT_LAST = ABITS'(DEPTH / 2 - 1);

    state_t           state, state_nxt;
    logic [ABITS-1:0] cnt, cnt_nxt;
    logic             prio, prio_nxt;     // 0: port A wins a conflict, 1: port B
    logic [ABITS-1:0] last_a, last_b;     // address held on an idle RAM port
    logic             conflict;
    logic             acc_a, acc_b;

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            prio        <= 1'b0;
            last_a      <= '0;
            last_b      <= '0;
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            prio        <= prio_nxt;
            last_a      <= ram_a_a;
            last_b      <= ram_a_b;
            rsp_valid_a <= acc_a && !req_we_a;
            rsp_valid_b <= acc_b && !req_we_b;
        end
    end

    // A collision only matters if at least one side writes; two reads of the
    // same word are harmless and both proceed.
    assign conflict = req_valid_a && req_valid_b && (req_addr_a == req_addr_b) &&
                      (req_we_a || req_we_b);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        prio_nxt    = prio;
        req_ready_a = 1'b0;
        req_ready_b = 1'b0;
        acc_a       = 1'b0;
        acc_b       = 1'b0;
        ram_a_a     = last_a;
        ram_a_b     = last_b;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        ram_wd_a    = req_wdata_a;
        ram_wd_b    = req_wdata_b;

        // NOTE: the RAM drive is combinational from state, so reset is also
        // gated in here; otherwise the INIT writes would be driven while rst
        // is still asserted.
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    ram_a_a  = {cnt[ABITS-2:0], 1'b0};
                    ram_a_b  = {cnt[ABITS-2:0], 1'b1};
                    ram_we_a = 1'b1;
                    ram_we_b = 1'b1;
                    ram_wd_a = INIT_VALUE;
                    ram_wd_b = INIT_VALUE;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    req_ready_a = !conflict || !prio;
                    req_ready_b = !conflict ||  prio;
                    acc_a       = req_valid_a && req_ready_a;
                    acc_b       = req_valid_b && req_ready_b;
                    if (acc_a) begin
                        ram_a_a  = req_addr_a;
                        ram_we_a = req_we_a;
                    end
                    if (acc_b) begin
                        ram_a_b  = req_addr_b;
                        ram_we_b = req_we_b;
                    end
                    // Round-robin on conflicts bounds the loser's stall to one cycle.
                    if (conflict) begin
                        prio_nxt = !prio;
                    end
                end
            endcase
        end
    end

    assign init_done  = (state == ST_RUN);
    assign rsp_data_a = ram_rd_a;
    assign rsp_data_b = ram_rd_b;

endmodule

// File: tb/tb_tdp_ram_requester.sv
module tb_tdp_ram_requester;

    localparam int               ABITS      = 4;
    localparam int               DBITS      = 36;
    localparam int               DEPTH      = 8;
    localparam int               NW         = 1 << ABITS;
    localparam logic [DBITS-1:0] INIT_VALUE = 36'hA_5C3C_F00D;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_done;
    logic             req_valid_a, req_ready_a, req_we_a, rsp_valid_a;
    logic [ABITS-1:0] req_addr_a;
    logic [DBITS-1:0] req_wdata_a, rsp_data_a;
    logic             req_valid_b, req_ready_b, req_we_b, rsp_valid_b;
    logic [ABITS-1:0] req_addr_b;
    logic [DBITS-1:0] req_wdata_b, rsp_data_b;
    logic [ABITS-1:0] ram_a_a, ram_a_b;
    logic [DBITS-1:0] ram_wd_a, ram_wd_b, ram_rd_a, ram_rd_b;
    logic             ram_we_a, ram_we_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdp_ram_requester #(
        .ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH), .INIT_VALUE(INIT_VALUE)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
        .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
        .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b),
        .ram_a_a(ram_a_a), .ram_wd_a(ram_wd_a), .ram_we_a(ram_we_a), .ram_rd_a(ram_rd_a),
        .ram_a_b(ram_a_b), .ram_wd_b(ram_wd_b), .ram_we_b(ram_we_b), .ram_rd_b(ram_rd_b)
    );

    // Read-first true-dual-port block RAM with registered read data.
    logic [DBITS-1:0] mem [0:NW-1];
    always @(posedge clk) begin
        ram_rd_a <= mem[ram_a_a];
        ram_rd_b <= mem[ram_a_b];
        if (ram_we_a) mem[ram_a_a] <= ram_wd_a;
        if (ram_we_b) mem[ram_a_b] <= ram_wd_b;
    end

    // ---------------- reference model ----------------
    // Word contents as the client should see them, the round-robin owner and
    // the response expected in the following cycle on each port.
    logic [DBITS-1:0] ref_mem   [0:NW-1];
    bit               ref_known [0:NW-1];
    bit               ref_prio;
    bit               model_on = 1'b0;
    bit               pend_v_a, pend_k_a, pend_v_b, pend_k_b;
    logic [DBITS-1:0] pend_d_a, pend_d_b;
    bit               sb_conf, sb_ra, sb_rb, sb_acc_a, sb_acc_b;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            ref_mem[i]   = INIT_VALUE;
            ref_known[i] = (i < DEPTH);
        end
        ref_prio = 1'b0;
        pend_v_a = 1'b0; pend_k_a = 1'b0; pend_d_a = '0;
        pend_v_b = 1'b0; pend_k_b = 1'b0; pend_d_b = '0;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (rsp_valid_a !== pend_v_a) begin
                errors++; $display("FAIL sb_rsp_valid_a: got %b want %b", rsp_valid_a, pend_v_a);
            end
            checks++;
            if (rsp_valid_b !== pend_v_b) begin
                errors++; $display("FAIL sb_rsp_valid_b: got %b want %b", rsp_valid_b, pend_v_b);
            end
            if (pend_v_a && pend_k_a) begin
                checks++;
                if (rsp_data_a !== pend_d_a) begin
                    errors++; $display("FAIL sb_rsp_data_a: got %h want %h", rsp_data_a, pend_d_a);
                end
            end
            if (pend_v_b && pend_k_b) begin
                checks++;
                if (rsp_data_b !== pend_d_b) begin
                    errors++; $display("FAIL sb_rsp_data_b: got %h want %h", rsp_data_b, pend_d_b);
                end
            end

            sb_conf = req_valid_a && req_valid_b && (req_addr_a == req_addr_b) &&
                      (req_we_a || req_we_b);
            sb_ra   = !sb_conf || !ref_prio;
            sb_rb   = !sb_conf || ref_prio;
            if (req_valid_a) begin
                checks++;
                if (req_ready_a !== sb_ra) begin
                    errors++; $display("FAIL sb_ready_a: got %b want %b", req_ready_a, sb_ra);
                end
            end
            if (req_valid_b) begin
                checks++;
                if (req_ready_b !== sb_rb) begin
                    errors++; $display("FAIL sb_ready_b: got %b want %b", req_ready_b, sb_rb);
                end
            end
            sb_acc_a = req_valid_a && sb_ra;
            sb_acc_b = req_valid_b && sb_rb;
            checks++;
            if (ram_we_a !== (sb_acc_a && req_we_a) || ram_we_b !== (sb_acc_b && req_we_b)) begin
                errors++;
                $display("FAIL sb_ram_we: got %b%b want %b%b", ram_we_a, ram_we_b,
                         sb_acc_a && req_we_a, sb_acc_b && req_we_b);
            end
            if (sb_acc_a) begin
                checks++;
                if (ram_a_a !== req_addr_a) begin
                    errors++; $display("FAIL sb_ram_a_a: got %0d want %0d", ram_a_a, req_addr_a);
                end
            end
            if (sb_acc_b) begin
                checks++;
                if (ram_a_b !== req_addr_b) begin
                    errors++; $display("FAIL sb_ram_a_b: got %0d want %0d", ram_a_b, req_addr_b);
                end
            end
            checks++;
            if (req_valid_a && req_ready_a && req_valid_b && req_ready_b &&
                req_addr_a == req_addr_b && (req_we_a || req_we_b)) begin
                errors++; $display("FAIL sb_collision: both ports granted addr %0d", req_addr_a);
            end

            pend_v_a = sb_acc_a && !req_we_a;
            pend_d_a = ref_mem[req_addr_a];
            pend_k_a = ref_known[req_addr_a];
            pend_v_b = sb_acc_b && !req_we_b;
            pend_d_b = ref_mem[req_addr_b];
            pend_k_b = ref_known[req_addr_b];
            if (sb_acc_a && req_we_a) begin
                ref_mem[req_addr_a] = req_wdata_a; ref_known[req_addr_a] = 1'b1;
            end
            if (sb_acc_b && req_we_b) begin
                ref_mem[req_addr_b] = req_wdata_b; ref_known[req_addr_b] = 1'b1;
            end
            if (sb_conf) ref_prio = !ref_prio;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    endtask

    task automatic set_a(input bit we, input logic [ABITS-1:0] addr, input logic [DBITS-1:0] d);
        req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = d;
    endtask

    task automatic set_b(input bit we, input logic [ABITS-1:0] addr, input logic [DBITS-1:0] d);
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = d;
    endtask

    function automatic logic [DBITS-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DBITS-1:0];
    endfunction

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++; $display("FAIL %s_init_timeout: init_done=%b after %0d cycles", tag, init_done, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_on = 1'b0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready_a, req_ready_b, ram_we_a, ram_we_b, rsp_valid_a, rsp_valid_b, init_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b we=%b%b rsp=%b%b done=%b want all 0",
                     req_ready_a, req_ready_b, ram_we_a, ram_we_b, rsp_valid_a, rsp_valid_b, init_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH / 2; i++) begin
            #1;
            checks++;
            if (ram_we_a !== 1'b1 || ram_we_b !== 1'b1 || ram_a_a !== ABITS'(2 * i) ||
                ram_a_b !== ABITS'(2 * i + 1) || ram_wd_a !== INIT_VALUE ||
                ram_wd_b !== INIT_VALUE || init_done !== 1'b0 ||
                req_ready_a !== 1'b0 || req_ready_b !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle%0d: we=%b%b a=%0d/%0d done=%b want we=11 a=%0d/%0d done=0",
                         i, ram_we_a, ram_we_b, ram_a_a, ram_a_b, init_done, 2 * i, 2 * i + 1);
            end
            @(negedge clk);
        end
        checks++;
        if (init_done !== 1'b1 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
            errors++;
            $display("FAIL init_done_rise: done=%b we=%b%b want done=1 we=00", init_done, ram_we_a, ram_we_b);
        end
        model_reset();
        model_on = 1'b1;
        tick();
        set_a(1'b0, 4'd6, '0);
        tick();
        idle();
        checks++;
        if (rsp_valid_a !== 1'b1 || rsp_data_a !== INIT_VALUE) begin
            errors++;
            $display("FAIL init_read6: valid=%b data=%h want 1/%h", rsp_valid_a, rsp_data_a, INIT_VALUE);
        end
        tick();
        checks++;
        if (rsp_valid_a !== 1'b0) begin
            errors++; $display("FAIL init_read6_single: valid=%b want 0", rsp_valid_a);
        end
    endtask

    task automatic test_raw_cross();
        set_a(1'b1, 4'd3, 36'h5A);
        tick();
        idle();
        set_b(1'b0, 4'd3, '0);
        tick();
        idle();
        checks++;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== 36'h5A) begin
            errors++; $display("FAIL raw_cross: valid=%b data=%h want 1/5a", rsp_valid_b, rsp_data_b);
        end
    endtask

    task automatic test_conflict();
        logic [DBITS-1:0] d1, d2;
        d1 = rnd_data();
        d2 = ~d1;
        set_a(1'b1, 4'd9, d1);
        set_b(1'b0, 4'd9, '0);
        #1;
        checks++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b0) begin
            errors++; $display("FAIL conflict1_ready: got %b%b want 10", req_ready_a, req_ready_b);
        end
        tick();
        req_valid_a = 1'b0;
        #1;
        checks++;
        if (req_ready_b !== 1'b1) begin
            errors++; $display("FAIL conflict1_b_next: ready_b=%b want 1", req_ready_b);
        end
        tick();
        idle();
        checks++;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== d1) begin
            errors++; $display("FAIL conflict1_data: valid=%b data=%h want 1/%h", rsp_valid_b, rsp_data_b, d1);
        end
        set_a(1'b1, 4'd9, d2);
        set_b(1'b0, 4'd9, '0);
        #1;
        checks++;
        if (req_ready_a !== 1'b0 || req_ready_b !== 1'b1) begin
            errors++; $display("FAIL conflict2_ready: got %b%b want 01", req_ready_a, req_ready_b);
        end
        tick();
        req_valid_b = 1'b0;
        checks++;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== d1) begin
            errors++; $display("FAIL conflict2_data: valid=%b data=%h want 1/%h", rsp_valid_b, rsp_data_b, d1);
        end
        #1;
        checks++;
        if (req_ready_a !== 1'b1) begin
            errors++; $display("FAIL conflict2_a_next: ready_a=%b want 1", req_ready_a);
        end
        tick();
        idle();
        set_a(1'b0, 4'd9, '0);
        tick();
        idle();
        checks++;
        if (rsp_valid_a !== 1'b1 || rsp_data_a !== d2) begin
            errors++; $display("FAIL conflict2_final: valid=%b data=%h want 1/%h", rsp_valid_a, rsp_data_a, d2);
        end
    endtask

    task automatic test_same_read();
        set_a(1'b0, 4'd4, '0);
        set_b(1'b0, 4'd4, '0);
        #1;
        checks++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1) begin
            errors++; $display("FAIL same_read_ready: got %b%b want 11", req_ready_a, req_ready_b);
        end
        tick();
        idle();
        checks++;
        if (rsp_valid_a !== 1'b1 || rsp_valid_b !== 1'b1 ||
            rsp_data_a !== INIT_VALUE || rsp_data_b !== INIT_VALUE) begin
            errors++;
            $display("FAIL same_read_rsp: valid=%b%b data=%h/%h want 11 %h",
                     rsp_valid_a, rsp_valid_b, rsp_data_a, rsp_data_b, INIT_VALUE);
        end
    endtask

    task automatic test_back_to_back();
        logic [DBITS-1:0] exp_d [0:NW-1];
        for (int i = 0; i < NW / 2; i++) begin
            exp_d[2 * i]     = rnd_data();
            exp_d[2 * i + 1] = rnd_data();
            set_a(1'b1, ABITS'(2 * i), exp_d[2 * i]);
            set_b(1'b1, ABITS'(2 * i + 1), exp_d[2 * i + 1]);
            tick();
        end
        idle();
        for (int i = 0; i < NW; i++) begin
            set_a(1'b0, ABITS'(i), '0);
            tick();
            checks++;
            if (rsp_valid_a !== 1'b1 || rsp_data_a !== exp_d[i]) begin
                errors++;
                $display("FAIL b2b_read%0d: valid=%b data=%h want 1/%h", i, rsp_valid_a, rsp_data_a, exp_d[i]);
            end
        end
        idle();
        tick();
        checks++;
        if (rsp_valid_a !== 1'b0) begin
            errors++; $display("FAIL b2b_end: valid=%b want 0", rsp_valid_a);
        end
    endtask

    task automatic test_random();
        bit hold_a, hold_b;
        for (int n = 0; n < 400; n++) begin
            if (!hold_a) begin
                req_valid_a = ($urandom_range(0, 9) < 7);
                req_we_a    = $urandom_range(0, 1) == 1;
                req_addr_a  = ABITS'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1)
                                                                : $urandom_range(0, 3));
                req_wdata_a = rnd_data();
            end
            if (!hold_b) begin
                req_valid_b = ($urandom_range(0, 9) < 7);
                req_we_b    = $urandom_range(0, 1) == 1;
                req_addr_b  = ABITS'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1)
                                                                : $urandom_range(0, 3));
                req_wdata_b = rnd_data();
            end
            #1;
            hold_a = req_valid_a && !req_ready_a;
            hold_b = req_valid_b && !req_ready_b;
            tick();
        end
        idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        model_on = 1'b0;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (ram_a_a !== 4'd4 || ram_a_b !== 4'd5) begin
            errors++; $display("FAIL mid_init_cnt2: a=%0d/%0d want 4/5", ram_a_a, ram_a_b);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_we_a, ram_we_b, req_ready_a, req_ready_b, init_done, rsp_valid_a, rsp_valid_b} !== 7'b0) begin
            errors++;
            $display("FAIL mid_init_reset: we=%b%b rdy=%b%b done=%b want all 0",
                     ram_we_a, ram_we_b, req_ready_a, req_ready_b, init_done);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ram_we_a !== 1'b1 || ram_we_b !== 1'b1 || ram_a_a !== 4'd0 || ram_a_b !== 4'd1) begin
            errors++;
            $display("FAIL mid_init_restart: we=%b%b a=%0d/%0d want 11 0/1", ram_we_a, ram_we_b, ram_a_a, ram_a_b);
        end
        wait_init("mid_init");
        model_reset();
        model_on = 1'b1;
        set_a(1'b0, 4'd2, '0);
        tick();
        idle();
        checks++;
        if (rsp_valid_a !== 1'b1) begin
            errors++; $display("FAIL mid_read_pre: valid=%b want 1", rsp_valid_a);
        end
        model_on = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid_a, rsp_valid_b, req_ready_a, req_ready_b, init_done, ram_we_a, ram_we_b} !== 7'b0) begin
            errors++;
            $display("FAIL mid_read_reset: rsp=%b%b rdy=%b%b done=%b we=%b%b want all 0",
                     rsp_valid_a, rsp_valid_b, req_ready_a, req_ready_b, init_done, ram_we_a, ram_we_b);
        end
        tick();
        rst = 1'b0;
        wait_init("mid_read");
        model_reset();
        model_on = 1'b1;
        set_b(1'b0, 4'd2, '0);
        tick();
        idle();
        checks++;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== INIT_VALUE) begin
            errors++;
            $display("FAIL mid_read_after: valid=%b data=%h want 1/%h", rsp_valid_b, rsp_data_b, INIT_VALUE);
        end
        tick();
        model_on = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_raw_cross();
        test_conflict();
        test_same_read();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
